// File: rtl/bitslip_pkg.sv
// Shared definitions for the ISERDES bitslip alignment controller:
// FSM state encoding, default tuning constants and a counter-width helper.
package bitslip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int unsigned       DEF_WORD_W   = 12;
    localparam logic [11:0]       DEF_PTTN     = 12'h03F;
    localparam int unsigned       DEF_SLIP_MAX = 6;
    localparam int unsigned       DEF_SETTLE   = 3;
    localparam int unsigned       DEF_MATCH_N  = 8;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bitslip_ctrl.sv
// Frame-word alignment: compares the deserialized word against the sync pattern
// and issues BITSLIP pulses until MATCH_N consecutive matches or all rotations fail.
module bitslip_ctrl
    import bitslip_pkg::*;
#(
    parameter int unsigned       WORD_W   = DEF_WORD_W,
    parameter logic [WORD_W-1:0] PTTN     = DEF_PTTN,
    parameter int unsigned       SLIP_MAX = DEF_SLIP_MAX,
    parameter int unsigned       SETTLE   = DEF_SETTLE,
    parameter int unsigned       MATCH_N  = DEF_MATCH_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic [WORD_W-1:0] des_data,
    output logic              bitslip,
    output logic              run,
    output logic              done,
    output logic              ok,
    output logic [2:0]        slip_cnt
);

    localparam int unsigned WAIT_W  = cnt_w(SETTLE);
    localparam int unsigned MATCH_W = cnt_w(MATCH_N);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [2:0]         slip_q, slip_d;
    logic               ok_q, ok_d;
    logic               bitslip_q, bitslip_d;
    logic               run_q, run_d;
    logic               done_q, done_d;

    logic               word_hit;

    assign word_hit = (des_data == PTTN);

    // NOTE: every variable gets its hold value before the case so no path
    // through this block leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        match_d = match_q;
        slip_d  = slip_q;
        ok_d    = ok_q;

        unique case (state_q)
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_SETTLE;
                    wait_d  = '0;
                    match_d = '0;
                    slip_d  = '0;
                    ok_d    = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (wait_q == WAIT_W'(SETTLE - 1)) begin
                    state_d = ST_CHECK;
                    wait_d  = '0;
                    match_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (word_hit) begin
                    if (match_q == MATCH_W'(MATCH_N - 1)) begin
                        state_d = ST_DONE;
                        ok_d    = 1'b1;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else begin
                    // Any mismatch voids the partial run; the last rotation failing ends the search.
                    match_d = '0;
                    if (slip_q == 3'(SLIP_MAX - 1)) begin
                        state_d = ST_DONE;
                        ok_d    = 1'b0;
                    end else begin
                        state_d = ST_SLIP;
                        slip_d  = slip_q + 3'd1;
                    end
                end
            end
            ST_SLIP: begin
                state_d = ST_SETTLE;
                wait_d  = '0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        bitslip_d = (state_d == ST_SLIP);
        done_d    = (state_d == ST_DONE);
        run_d     = (state_d != ST_IDLE);
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous, checked only on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            match_q   <= '0;
            slip_q    <= '0;
            ok_q      <= 1'b0;
            bitslip_q <= 1'b0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            match_q   <= match_d;
            slip_q    <= slip_d;
            ok_q      <= ok_d;
            bitslip_q <= bitslip_d;
            run_q     <= run_d;
            done_q    <= done_d;
        end
    end

    assign bitslip  = bitslip_q;
    assign run      = run_q;
    assign done     = done_q;
    assign ok       = ok_q;
    assign slip_cnt = slip_q;

endmodule

// File: tb/tb_bitslip_ctrl.sv
// Directed bench for bitslip_ctrl: aligned input, rotated ISERDES model,
// unalignable input, broken match run, reset during CHECK and ignored init.
module tb_bitslip_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic [11:0] des_data;
    logic        bitslip;
    logic        run;
    logic        done;
    logic        ok;
    logic [2:0]  slip_cnt;

    int checks   = 0;
    int failures = 0;

    // Results of the last alignment run, in cycles counted from the init cycle (cycle 0).
    int n_pulse;
    int p0_cyc;
    int p1_cyc;
    int done_cyc;
    int n_done;
    int run_err;

    bitslip_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .des_data (des_data),
        .bitslip  (bitslip),
        .run      (run),
        .done     (done),
        .ok       (ok),
        .slip_cnt (slip_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] rotl12(input logic [11:0] w, input int n);
        return (w << n) | (w >> (12 - n));
    endfunction

    // mode 0: constant word; mode 1: ISERDES rotated by rot0 slips, each pulse removes one;
    // mode 2: constant word inverted in cycle glitch_cyc only.
    function automatic logic [11:0] word_for(input int mode, input logic [11:0] val,
                                             input int rot0, input int slips,
                                             input int glitch_cyc, input int cyc);
        int pos;
        pos = (((rot0 - slips) % 6) + 6) % 6;
        case (mode)
            1:       return rotl12(val, 2 * pos);
            2:       return (cyc == glitch_cyc) ? ~val : val;
            default: return val;
        endcase
    endfunction

    task automatic run_align(input int mode, input logic [11:0] val, input int rot0,
                             input int glitch_cyc, input int init_again);
        int slips;
        n_pulse  = 0;
        p0_cyc   = -1;
        p1_cyc   = -1;
        done_cyc = -1;
        n_done   = 0;
        run_err  = 0;
        slips    = 0;
        init     = 1'b1;
        des_data = word_for(mode, val, rot0, 0, glitch_cyc, 0);
        step();
        for (int cyc = 1; cyc <= 120; cyc++) begin
            des_data = word_for(mode, val, rot0, slips, glitch_cyc, cyc);
            init     = (cyc == init_again);
            if (bitslip) begin
                if (n_pulse == 0) p0_cyc = cyc;
                if (n_pulse == 1) p1_cyc = cyc;
                n_pulse++;
                slips++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc < 0 || cyc == done_cyc) begin
                if (!run) run_err++;
            end else if (run) begin
                run_err++;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            step();
        end
        init = 1'b0;
    endtask

    initial begin
        int run_seen;
        int slip_seen;

        rst      = 1'b1;
        init     = 1'b0;
        des_data = 12'h000;
        step();
        step();
        check("rst_bitslip",  32'(bitslip),  32'd0);
        check("rst_run",      32'(run),      32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_ok",       32'(ok),       32'd0);
        check("rst_slip_cnt", 32'(slip_cnt), 32'd0);

        rst = 1'b0;
        repeat (3) step();
        check("idle_no_autostart_run", 32'(run), 32'd0);

        // Aligned stream: best-case latency, no slips.
        run_align(0, 12'h03F, 0, -1, -1);
        check("aligned_pulses",   32'(n_pulse),  32'd0);
        check("aligned_done_cyc", 32'(done_cyc), 32'd12);
        check("aligned_n_done",   32'(n_done),   32'd1);
        check("aligned_run",      32'(run_err),  32'd0);
        check("aligned_ok",       32'(ok),       32'd1);
        check("aligned_slip_cnt", 32'(slip_cnt), 32'd0);

        // Model rotated two positions: slips at 5 and 10, success at 14..21, done at 22.
        run_align(1, 12'h03F, 2, -1, -1);
        check("rot2_pulses",   32'(n_pulse),         32'd2);
        check("rot2_first",    32'(p0_cyc),          32'd5);
        check("rot2_spacing",  32'(p1_cyc - p0_cyc), 32'd5);
        check("rot2_done_cyc", 32'(done_cyc),        32'd22);
        check("rot2_run",      32'(run_err),         32'd0);
        check("rot2_ok",       32'(ok),              32'd1);
        check("rot2_slip_cnt", 32'(slip_cnt),        32'd2);

        // Never matches: five slips, sixth mismatch at cycle 29 ends with ok=0 at cycle 30.
        run_align(0, 12'hAAA, 0, -1, -1);
        check("aaa_pulses",   32'(n_pulse),  32'd5);
        check("aaa_done_cyc", 32'(done_cyc), 32'd30);
        check("aaa_n_done",   32'(n_done),   32'd1);
        check("aaa_ok",       32'(ok),       32'd0);
        check("aaa_slip_cnt", 32'(slip_cnt), 32'd5);
        repeat (4) step();
        check("aaa_hold_ok",       32'(ok),       32'd0);
        check("aaa_hold_slip_cnt", 32'(slip_cnt), 32'd5);

        // Matches in cycles 4..8, mismatch at 9: slip at 10, eight fresh matches 14..21.
        run_align(2, 12'h03F, 0, 9, -1);
        check("glitch_pulses",   32'(n_pulse),  32'd1);
        check("glitch_pulse_at", 32'(p0_cyc),   32'd10);
        check("glitch_done_cyc", 32'(done_cyc), 32'd22);
        check("glitch_ok",       32'(ok),       32'd1);
        check("glitch_slip_cnt", 32'(slip_cnt), 32'd1);

        // init pulsed mid-run (cycle 7) must not restart or add a done pulse.
        run_align(0, 12'h03F, 0, -1, 7);
        check("reinit_done_cyc", 32'(done_cyc), 32'd12);
        check("reinit_n_done",   32'(n_done),   32'd1);
        check("reinit_pulses",   32'(n_pulse),  32'd0);
        check("reinit_ok",       32'(ok),       32'd1);
        check("reinit_slip_cnt", 32'(slip_cnt), 32'd0);

        // Reset in CHECK (cycle 14 of an unalignable run, two slips done), with init also high.
        init     = 1'b1;
        des_data = 12'hAAA;
        step();
        init = 1'b0;
        repeat (13) step();
        check("pre_rst_run",      32'(run),      32'd1);
        check("pre_rst_slip_cnt", 32'(slip_cnt), 32'd2);
        rst  = 1'b1;
        init = 1'b1;
        step();
        check("mid_rst_bitslip",  32'(bitslip),  32'd0);
        check("mid_rst_run",      32'(run),      32'd0);
        check("mid_rst_done",     32'(done),     32'd0);
        check("mid_rst_ok",       32'(ok),       32'd0);
        check("mid_rst_slip_cnt", 32'(slip_cnt), 32'd0);
        rst  = 1'b0;
        init = 1'b0;
        run_seen  = 0;
        slip_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (run) run_seen++;
            if (bitslip) slip_seen++;
        end
        check("post_rst_idle_run",     32'(run_seen),  32'd0);
        check("post_rst_idle_bitslip", 32'(slip_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitslip_ctrl.md
BITSLIP_CTRL -- requirements
Module: bitslip_ctrl

Interface
REQ-001 Parameter WORD_W, default 12: width of the deserialized frame word.
REQ-002 Parameter PTTN, default 12'h03F: expected ADC sync-pattern word.
REQ-003 Parameter SLIP_MAX, default 6: bitslips per full word rotation, equal to the deserialization ratio.
REQ-004 Parameter SETTLE, default 3: idle cycles after each bitslip, or after start, before compare.
REQ-005 Parameter MATCH_N, default 8: consecutive matching words required to declare alignment.
REQ-006 Port clk, input, 1: frame clock (FCO_des domain); the only clock.
REQ-007 Port rst, input, 1: reset, synchronous, active-high.
REQ-008 Port init, input, 1: start-alignment pulse (driven by BS_init).
REQ-009 Port des_data, input, WORD_W: ISERDES parallel output word.
REQ-010 Port bitslip, output, 1: one-cycle BITSLIP pulse to all ISERDES of the channel.
REQ-011 Port run, output, 1: alignment in progress (drives BS_confrun).
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port ok, output, 1: alignment result level.
REQ-014 Port slip_cnt, output, 3: bitslips issued in the current or last run.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, CHECK, SLIP and DONE; all outputs SHALL be registered.
REQ-016 In IDLE, run SHALL be 0 and init=1 SHALL move the FSM to SETTLE, clearing ok, slip_cnt, the wait counter and the match counter.
REQ-017 init SHALL be ignored in every state except IDLE.
REQ-018 In SETTLE, the FSM SHALL stay exactly SETTLE cycles and then enter CHECK with the match counter at 0.
REQ-019 In CHECK, each cycle with des_data==PTTN SHALL increment the match counter; the MATCH_N-th consecutive match SHALL enter DONE with ok=1.
REQ-020 In CHECK, any mismatch SHALL reset the match counter, including after a partial run of matches.
REQ-021 On a mismatch with slip_cnt<SLIP_MAX-1, the FSM SHALL enter SLIP.
REQ-022 On a mismatch with slip_cnt==SLIP_MAX-1, all alignments have been tested and the FSM SHALL enter DONE with ok=0.
REQ-023 In SLIP, bitslip SHALL be 1 for exactly one cycle, slip_cnt SHALL increment by 1, and the next state SHALL be SETTLE.
REQ-024 Consecutive bitslip pulses SHALL therefore be spaced at least SETTLE+2 cycles apart.
REQ-025 In DONE, done SHALL be 1 for one cycle and the next state SHALL be IDLE.
REQ-026 ok and slip_cnt SHALL hold their values until the next accepted init or rst.
REQ-027 run SHALL be 1 in SETTLE, CHECK, SLIP and DONE, and 0 in IDLE.
REQ-028 Best-case latency: init sampled at cycle 0 SHALL give done at cycle 1+SETTLE+MATCH_N, which is cycle 12 with default parameters.
REQ-029 slip_cnt SHALL never exceed SLIP_MAX-1 and SHALL never wrap.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and bitslip=0, run=0, done=0, ok=0, slip_cnt=0 and all internal counters to 0, from any state.
REQ-031 rst SHALL take priority over init in the same cycle.
REQ-032 After rst is released, a new init SHALL be required to start alignment.

Structure
REQ-033 Shared package bitslip_pkg SHALL hold the FSM state encoding and the default PTTN, SLIP_MAX, SETTLE and MATCH_N constants.
REQ-034 No sub-module is required; the wait, match and slip counters SHALL be implemented inline.

Verification
REQ-035 Constant des_data=12'h03F, init at cycle 0 -> no bitslip pulse; done at cycle 12; ok=1; slip_cnt=0.
REQ-036 ISERDES model rotated 2 positions -> exactly 2 bitslip pulses spaced 5 cycles apart; then ok=1, slip_cnt=2.
REQ-037 des_data=12'hAAA constant -> 5 bitslip pulses; done; ok=0; slip_cnt=5.
REQ-038 5 matching words then 1 mismatching word -> one bitslip pulse, match counter restarts, success after 8 further matches.
REQ-039 rst during CHECK -> next cycle all outputs 0 and state IDLE; init asserted while run=1 -> no restart, no extra done pulse.
